ber_checker_prbs: RTL
=====================

// Module: ber_checker_prbs
// PURPOSE
// - Receiver-side counterpart of the TX PRBS9 generator. Compares the slicer hard decision (one branch, I or Q) with the TX reference bit.
// - Locks onto the unknown end-to-end latency (TX filter, channel, AA filter, FSE, downsamplers, slicer) by exhaustive search.
// - Once locked, accumulates bit and error counts for BER measurement.
// - The top level instantiates one checker per branch (I and Q).
// PARAMETERS
// - NB_LAT    9    width of the latency index; candidate latencies are 0..2**NB_LAT-1.
// - WINDOW    511  symbols compared per candidate latency (one full PRBS9 period).
// - LOCK_THR  8    maximum errors in a window for a candidate to be accepted.
// - NB_CNT    32   width of the bit and error counters.
// PORTS
// - clk          in   1       system clock.
// - i_reset      in   1       asynchronous, active-low reset.
// - i_enable     in   1       symbol strobe; one cycle high per baud. All state advances only on strobe cycles.
// - i_clear      in   1       synchronous restart: counters are zeroed and a new search begins.
// - i_ref_bit    in   1       TX PRBS bit for the current symbol.
// - i_rx_bit     in   1       slicer decision, already mapped to PRBS polarity (1 = negative symbol).
// - o_locked     out  1       high while in LOCKED.
// - o_searching  out  1       high while in SEARCH.
// - o_latency    out  NB_LAT  latency in use, in symbols. Valid while o_locked is high.
// - o_bit_count  out  NB_CNT  symbols compared since lock.
// - o_err_count  out  NB_CNT  mismatches since lock.
// BEHAVIOUR
// - Reset values:
//   - All outputs 0.
//   - FSM in SEARCH with candidate 0.
//   - Delay line all zeros.
//   - Window counter 0 and error accumulator 0.
//   - Best-error register = all ones.
// - Delay line: on each strobe, i_ref_bit shifts into a (2**NB_LAT)-deep register. Tap k holds the reference delayed by k strobes. Tap 0 is the current i_ref_bit (combinational bypass).
// - The error term on each strobe is tap[cand] ^ i_rx_bit.
// - FSM state SEARCH:
//   - Per strobe: increment the window counter; add the error term to the accumulator.
//   - On the strobe that completes WINDOW symbols, the candidate has accumulated errors e:
//     - If e <= LOCK_THR and e < best: store best = e and best_lat = cand.
//     - Reset the window counter and accumulator to 0; increment cand.
//   - When cand wraps from 2**NB_LAT-1 to 0:
//     - If best <= LOCK_THR, go to LOCKED with o_latency = best_lat.
//     - Otherwise stay in SEARCH, reset best to all ones, and sweep again.
//   - Ties keep the lowest latency, because replacement requires strictly fewer errors.
// - FSM state LOCKED:
//   - Per strobe: o_bit_count += 1 and o_err_count += error term, using tap[o_latency].
//   - Counts are registered, so they are visible 1 cycle after the strobe.
//   - There is no automatic unlock; the system restarts the checker with i_clear.
// - Saturation: when o_bit_count == all ones, both counters freeze, so the ratio stays consistent. o_err_count cannot exceed o_bit_count.
// - i_clear (synchronous, any state):
//   - Next cycle: SEARCH, cand 0, counters 0, best all ones.
//   - The delay line is preserved.
//   - i_clear takes priority over a simultaneous strobe; that strobe's comparison is discarded, but its ref bit still shifts in.
// - i_enable low: all registers hold.
// - Asynchronous reset deasserted mid-operation: resume from reset values on the next strobe.
// - Worst-case search time is 2**NB_LAT * WINDOW strobes.
// STRUCTURE
// - Shared package:
//   - State encoding localparams: ST_SEARCH = 1'b0, ST_LOCKED = 1'b1.
//   - The PRBS9 period constant (511).
//   - The PRBS9 polynomial, shared with the TX generator.
// - One sub-module, ref_delay_line (NB_LAT parameter):
//   - Ports: clk, i_reset, i_enable, i_bit, i_sel, o_bit.
//   - Contents: shift register plus tap mux.
// - The parent holds the FSM, window/accumulator logic, best tracking and output counters.
// TESTING
// - Ref = PRBS9 (seed 9'h1AA); rx = ref delayed 37 strobes, error-free.
//   -> o_locked rises after sweep 1; o_latency = 37; after 1000 locked strobes, bit = 1000 and err = 0.
// - Same stream with rx inverted on every 100th symbol, delay 37.
//   -> lock at 37; err = bit/100 (+/-1).
// - rx = ~ref (all bits wrong), any delay.
//   -> o_locked stays 0; o_searching stays 1 across 2 full sweeps.
// - Lock at delay 12, then assert i_clear, then change the channel delay to 200.
//   -> counters read 0 the cycle after clear; relock with o_latency = 200.
// - i_clear and i_enable asserted in the same cycle while LOCKED.
//   -> counters 0 and no increment.
// - Async reset pulse mid-SEARCH -> all outputs 0 immediately.
// - NB_CNT = 4, locked, error-free.
//   -> bit saturates at 15 and err stays 0. Then inject errors -> both counters stay frozen.

Source files
------------

// File: rtl/ber_checker_prbs_pkg.sv
// rtl/ber_checker_prbs_pkg.sv - shared PRBS9 constants and checker state encoding
package ber_checker_prbs_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int         PRBS9_PERIOD = 511;
    // x^9 + x^5 + 1, same taps as the TX generator
    localparam logic [8:0] PRBS9_POLY   = 9'h110;

    function automatic logic [8:0] prbs9_next(input logic [8:0] state);
        return {state[7:0], ^(state & PRBS9_POLY)};
    endfunction

endpackage

// File: rtl/ber_checker_prbs_ref_delay_line.sv
// rtl/ber_checker_prbs_ref_delay_line.sv - reference bit delay line with selectable tap
module ref_delay_line #(
    parameter int NB_LAT = 9
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_bit,
    input  logic [NB_LAT-1:0] i_sel,
    output logic              o_bit
);

    localparam int DEPTH = 2**NB_LAT;

    logic [DEPTH-1:1] taps;
    logic [DEPTH-1:0] all_taps;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            taps <= '0;
        end else if (i_enable) begin
            taps <= {taps[DEPTH-2:1], i_bit};
        end
    end

    // Tap 0 bypasses the register so a zero-latency channel can be matched.
    assign all_taps = {taps, i_bit};
    assign o_bit    = all_taps[i_sel];

endmodule

// File: rtl/ber_checker_prbs.sv
// rtl/ber_checker_prbs.sv - PRBS bit-error-rate checker with exhaustive latency search
module ber_checker_prbs
    import ber_checker_prbs_pkg::*;
#(
    parameter int NB_LAT   = 9,
    parameter int WINDOW   = PRBS9_PERIOD,
    parameter int LOCK_THR = 8,
    parameter int NB_CNT   = 32
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic              i_ref_bit,
    input  logic              i_rx_bit,
    output logic              o_locked,
    output logic              o_searching,
    output logic [NB_LAT-1:0] o_latency,
    output logic [NB_CNT-1:0] o_bit_count,
    output logic [NB_CNT-1:0] o_err_count
);

    localparam int                NB_WIN   = $clog2(WINDOW + 1);
    localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(WINDOW - 1);
    localparam logic [NB_WIN-1:0] THR      = NB_WIN'(LOCK_THR);

    state_t              state, state_n;
    logic [NB_LAT-1:0]   cand, cand_n;
    logic [NB_WIN-1:0]   win_cnt, win_cnt_n;
    logic [NB_WIN-1:0]   err_acc, err_acc_n;
    logic [NB_WIN-1:0]   best_err, best_err_n;
    logic [NB_LAT-1:0]   best_lat, best_lat_n;
    logic [NB_LAT-1:0]   latency_n;
    logic [NB_CNT-1:0]   bit_count_n, err_count_n;
    logic                searching_n;
    logic [NB_LAT-1:0]   tap_sel;
    logic                tap_bit;
    logic                err_term;
    logic [NB_WIN-1:0]   err_total;

    assign tap_sel = (state == ST_LOCKED) ? o_latency : cand;

    ref_delay_line #(
        .NB_LAT (NB_LAT)
    ) u_ref_delay_line (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_bit    (i_ref_bit),
        .i_sel    (tap_sel),
        .o_bit    (tap_bit)
    );

    assign err_term  = tap_bit ^ i_rx_bit;
    assign err_total = err_acc + NB_WIN'(err_term);
    assign o_locked  = (state == ST_LOCKED);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_SEARCH;
            cand        <= '0;
            win_cnt     <= '0;
            err_acc     <= '0;
            best_err    <= '1;
            best_lat    <= '0;
            o_latency   <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
            o_searching <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            win_cnt     <= win_cnt_n;
            err_acc     <= err_acc_n;
            best_err    <= best_err_n;
            best_lat    <= best_lat_n;
            o_latency   <= latency_n;
            o_bit_count <= bit_count_n;
            o_err_count <= err_count_n;
            o_searching <= searching_n;
        end
    end

    always_comb begin
        state_n     = state;
        cand_n      = cand;
        win_cnt_n   = win_cnt;
        err_acc_n   = err_acc;
        best_err_n  = best_err;
        best_lat_n  = best_lat;
        latency_n   = o_latency;
        bit_count_n = o_bit_count;
        err_count_n = o_err_count;
        searching_n = o_searching;

        if (i_clear) begin
            state_n     = ST_SEARCH;
            cand_n      = '0;
            win_cnt_n   = '0;
            err_acc_n   = '0;
            best_err_n  = '1;
            best_lat_n  = '0;
            latency_n   = '0;
            bit_count_n = '0;
            err_count_n = '0;
        end else if (i_enable) begin
            case (state)
                ST_SEARCH: begin
                    win_cnt_n = win_cnt + NB_WIN'(1);
                    err_acc_n = err_total;
                    if (win_cnt == WIN_LAST) begin
                        win_cnt_n = '0;
                        err_acc_n = '0;
                        cand_n    = cand + NB_LAT'(1);
                        // Strictly-fewer keeps the lowest latency on ties.
                        if (err_total <= THR && err_total < best_err) begin
                            best_err_n = err_total;
                            best_lat_n = cand;
                        end
                        if (&cand) begin
                            if (best_err_n <= THR) begin
                                state_n   = ST_LOCKED;
                                latency_n = best_lat_n;
                            end else begin
                                best_err_n = '1;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    // Both counters freeze together so the ratio stays meaningful.
                    if (!(&o_bit_count)) begin
                        bit_count_n = o_bit_count + NB_CNT'(1);
                        err_count_n = o_err_count + NB_CNT'(err_term);
                    end
                end
                default: state_n = ST_SEARCH;
            endcase
        end

        if (i_clear || i_enable) begin
            searching_n = (state_n == ST_SEARCH);
        end
    end

endmodule
